amstrad_ram_sched: RTL and testbench
====================================

# amstrad_ram_sched

Shared-RAM slot scheduler between the Z80 and the Gate Array video fetch. It splits each 1 µs period (four `CE_4` ticks) into two video slots and two CPU slots, and generates the `phase` count the GA consumes. It stretches every CPU memory/IO cycle with `cpu_wait` so accesses align to the CPU slot. It also issues RAM writes, GA register writes and interrupt acknowledges.

## Interface
Parameters:
- none; all widths fixed by the CPC memory map.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `CE_4` in 1: 4 MHz clock-enable strobe; consecutive strobes ≥2 `CLK` apart.
- `phase` out 2: slot counter, drives GA `phase`.
- `crtc_ma` in 14: CRTC memory address.
- `crtc_ra` in 5: CRTC raster address; only [2:0] used.
- `cpu_a` in 16: Z80 address.
- `cpu_dout` in 8: Z80 write data.
- `cpu_mreq`, `cpu_iorq`, `cpu_rd`, `cpu_wr`, `cpu_m1` in 1 each: Z80 strobes, active-high.
- `cpu_wait` out 1: stretch request to the Z80, active-high.
- `cpu_din` out 8: read data to the Z80.
- `ram_a` out 15: RAM word address.
- `ram_d` out 8: RAM write byte.
- `ram_be` out 2: RAM byte lane enables.
- `ram_we` out 1: RAM write pulse.
- `ram_q` in 16: RAM read word.
  - Synchronous RAM, 1-`CLK` latency.
  - Even byte on [7:0], odd byte on [15:8].
- `vram_D` out 16: held video word, to GA.
- `ga_we` out 1: GA register write pulse (GA `WE`).
- `ga_d` out 8: GA register write data (GA `D`).
- `INTack` out 1: interrupt acknowledge pulse, to GA.

## Operation
- **Slot tick:** a `CLK` where `CE_4`=1 and `phase`==N; `phase` increments (mod 4) on every such tick.
- **Address mux (combinational on `phase`):**
  - `phase` 0/1: `ram_a` = {ma[13:12], ra[2:0], ma[9:0]}.
  - `phase` 2/3: `ram_a` = `cpu_a[15:1]`.
- **Video:** on each slot-1 tick, `vram_D` <= `ram_q`. `vram_D` holds through the rest of the period.
- **Request term:** `req` = ((`cpu_mreq`|`cpu_iorq`) & (`cpu_rd`|`cpu_wr`)) | (`cpu_m1` & `cpu_iorq`).
- **FSM states:** IDLE, SYNC, GRANT, DONE.
  - IDLE→SYNC on any `CLK` with `req`=1.
  - SYNC→GRANT on a slot-2 tick.
  - GRANT→DONE on a slot-3 tick.
  - DONE→IDLE on any `CLK` with `req`=0.
  - `req` dropping in SYNC or GRANT returns the FSM to IDLE; no side effects are issued.
- **`cpu_wait`:** combinational, = `req` & (state != DONE).
- **Actions on the `CLK` after the slot-2 tick (registered, exactly one `CLK`):**
  - Memory write: `ram_we`=1; `ram_be` = `cpu_a[0]` ? 2'b10 : 2'b01; `ram_d` = `cpu_dout`.
  - IO write with `cpu_a[15:14]`==2'b01: `ga_we`=1, `ga_d` = `cpu_dout`.
  - `cpu_m1` & `cpu_iorq`: `INTack`=1.
- **Slot-3 tick:**
  - Memory read: `cpu_din` <= `cpu_a[0]` ? `ram_q[15:8]` : `ram_q[7:0]`.
  - IO read or INTack: `cpu_din` <= 8'hFF.
- **Reset values:** `phase`=0; state=IDLE; `cpu_wait`=0; `ram_we`=0; `ram_be`=0; `ga_we`=0; `INTack`=0; `cpu_din`=8'hFF; `vram_D`=0; `ga_d`=0; `ram_d`=0.
- **Reset mid-access:** any pending write or INTack is dropped.

## Timing
- **`CE_4` low:** `phase` holds; no slot action occurs.
- **Request latency:**
  - A request entering SYNC before a slot-2 tick is granted at that tick.
  - A request entering SYNC on the same `CLK` as a slot-2 tick waits a full period (4 ticks).
- **Wait release:** `cpu_wait` falls on the `CLK` after the slot-3 tick. `cpu_din` is valid from that same `CLK`.
- **Back-to-back requests:** DONE must pass through IDLE (`req` low ≥1 `CLK`) before a new grant. No second action occurs within one Z80 cycle.
- **Write address stability:** `ram_we` coincides with `phase`==3, so `ram_a` is the CPU word during the write.
- **Video staleness:** the video fetch never waits on the CPU. `vram_D` is at most 1 period stale.

## Structure
- **Shared package `amstrad_pkg`:**
  - FSM state enum.
  - Slot constants: `SLOT_VID0`=0, `SLOT_VID1`=1, `SLOT_CPU`=2, `SLOT_DONE`=3.
  - `GA_IO_SEL`=2'b01.
- **Sub-module:** one natural sub-module, `amstrad_cpu_sync`, containing the FSM plus `cpu_wait`/`cpu_din` logic. Phase counter and address mux stay in the top.

## Test plan
- **Reset/video:** reset, then 8 `CE_4` ticks → `phase` sequence 1,2,3,0,1,2,3,0. With ma=14'h3001, ra=3'd2: `ram_a`=15'h6801 in phases 0/1. `vram_D` = RAM word after the slot-1 tick.
- **Memory write:** `cpu_mreq`+`cpu_wr` to 16'hC001, data 8'hA5, asserted at `phase`==0 → `cpu_wait` high immediately. `ram_we` pulses 1 `CLK` with `ram_a`=15'h6000 and `ram_be`=2'b10. `cpu_wait` drops after the slot-3 tick.
- **Memory read:** read of 16'h4000 with `ram_q`=16'h1234 → `cpu_din`=8'h34 when `cpu_wait` falls. A read of 16'h4001 returns 8'h12.
- **Grant edge:** request raised on the exact slot-2 tick `CLK` → no action that period. Granted 4 ticks later; `cpu_wait` high for ≥5 ticks.
- **GA write and INTack:** IO write to 16'h7F00, data 8'h8C → `ga_we` 1 `CLK`, `ga_d`=8'h8C, `ram_we` stays 0. `cpu_m1`+`cpu_iorq` → `INTack` 1 `CLK`, `cpu_din`=8'hFF.
- **Abort and reset:** `req` dropped while in SYNC → no `ram_we`. `RESET` asserted in GRANT → no `ram_we`, `cpu_wait`=0, `phase`=0 next `CLK`.

Source files
------------

// File: rtl/amstrad_pkg.sv
// Shared types and constants for the CPC shared-RAM slot scheduler.
package amstrad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_GRANT = 2'd2,
    ST_DONE  = 2'd3
  } sync_state_e;

  localparam logic [1:0] SLOT_VID0 = 2'd0;
  localparam logic [1:0] SLOT_VID1 = 2'd1;
  localparam logic [1:0] SLOT_CPU  = 2'd2;
  localparam logic [1:0] SLOT_DONE = 2'd3;

  localparam logic [1:0] GA_IO_SEL = 2'b01;

  // RAM words hold the even byte low and the odd byte high.
  function automatic logic [7:0] sel_byte(input logic odd, input logic [15:0] word);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/amstrad_ram_sched_if.sv
// Bus bundle between the scheduler and its surroundings (CPU, CRTC, RAM, GA).
interface amstrad_ram_sched_if;
  logic        CE_4;
  logic [1:0]  phase;
  logic [13:0] crtc_ma;
  logic [4:0]  crtc_ra;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq;
  logic        cpu_iorq;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_m1;
  logic        cpu_wait;
  logic [7:0]  cpu_din;
  logic [14:0] ram_a;
  logic [7:0]  ram_d;
  logic [1:0]  ram_be;
  logic        ram_we;
  logic [15:0] ram_q;
  logic [15:0] vram_D;
  logic        ga_we;
  logic [7:0]  ga_d;
  logic        INTack;

  modport slave (
    input  CE_4, crtc_ma, crtc_ra, cpu_a, cpu_dout,
           cpu_mreq, cpu_iorq, cpu_rd, cpu_wr, cpu_m1, ram_q,
    output phase, cpu_wait, cpu_din, ram_a, ram_d, ram_be, ram_we,
           vram_D, ga_we, ga_d, INTack
  );

  modport master (
    output CE_4, crtc_ma, crtc_ra, cpu_a, cpu_dout,
           cpu_mreq, cpu_iorq, cpu_rd, cpu_wr, cpu_m1, ram_q,
    input  phase, cpu_wait, cpu_din, ram_a, ram_d, ram_be, ram_we,
           vram_D, ga_we, ga_d, INTack
  );
endinterface

// File: rtl/amstrad_cpu_sync.sv
// Aligns each Z80 bus cycle to the CPU slot: holds WAIT, issues the write /
// GA-write / INTack pulse after the slot-2 tick and latches read data on slot 3.
module amstrad_cpu_sync
  import amstrad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_4,
  input  logic [1:0]  phase,
  input  logic [1:0]  io_sel,
  input  logic        a0,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq,
  input  logic        cpu_iorq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_m1,
  input  logic [15:0] ram_q,
  output logic        cpu_wait,
  output logic [7:0]  cpu_din,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic [7:0]  ram_d,
  output logic        ga_we,
  output logic [7:0]  ga_d,
  output logic        int_ack
);

  sync_state_e state_q, state_d;
  logic        ram_we_q, ram_we_d;
  logic [1:0]  ram_be_q, ram_be_d;
  logic [7:0]  ram_d_q, ram_d_d;
  logic        ga_we_q, ga_we_d;
  logic [7:0]  ga_d_q, ga_d_d;
  logic        int_ack_q, int_ack_d;
  logic [7:0]  cpu_din_q, cpu_din_d;

  logic req, mem_wr, mem_rd, io_wr, io_rd, ack;

  always_comb begin
    ack    = cpu_m1 & cpu_iorq;
    req    = ((cpu_mreq | cpu_iorq) & (cpu_rd | cpu_wr)) | ack;
    mem_wr = cpu_mreq & cpu_wr;
    mem_rd = cpu_mreq & cpu_rd;
    io_wr  = cpu_iorq & cpu_wr & ~cpu_m1 & (io_sel == GA_IO_SEL);
    io_rd  = cpu_iorq & cpu_rd;

    state_d   = state_q;
    ram_we_d  = 1'b0;
    ga_we_d   = 1'b0;
    int_ack_d = 1'b0;
    ram_be_d  = ram_be_q;
    ram_d_d   = ram_d_q;
    ga_d_d    = ga_d_q;
    cpu_din_d = cpu_din_q;

    case (state_q)
      ST_IDLE: if (req) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (ce_4 && phase == SLOT_CPU) begin
          // Pulses land while phase==3, when ram_a already shows the CPU word.
          state_d   = ST_GRANT;
          ram_we_d  = mem_wr;
          ga_we_d   = io_wr;
          int_ack_d = ack;
          if (mem_wr) begin
            ram_be_d = a0 ? 2'b10 : 2'b01;
            ram_d_d  = cpu_dout;
          end
          if (io_wr) ga_d_d = cpu_dout;
        end
      end
      ST_GRANT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (ce_4 && phase == SLOT_DONE) begin
          state_d = ST_DONE;
          if (mem_rd)             cpu_din_d = sel_byte(a0, ram_q);
          else if (io_rd || ack)  cpu_din_d = 8'hFF;
        end
      end
      ST_DONE: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ram_we_q  <= 1'b0;
      ram_be_q  <= 2'b00;
      ram_d_q   <= 8'h00;
      ga_we_q   <= 1'b0;
      ga_d_q    <= 8'h00;
      int_ack_q <= 1'b0;
      cpu_din_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      ram_we_q  <= ram_we_d;
      ram_be_q  <= ram_be_d;
      ram_d_q   <= ram_d_d;
      ga_we_q   <= ga_we_d;
      ga_d_q    <= ga_d_d;
      int_ack_q <= int_ack_d;
      cpu_din_q <= cpu_din_d;
    end
  end

  assign cpu_wait = req & (state_q != ST_DONE) & ~rst;
  assign cpu_din  = cpu_din_q;
  assign ram_we   = ram_we_q;
  assign ram_be   = ram_be_q;
  assign ram_d    = ram_d_q;
  assign ga_we    = ga_we_q;
  assign ga_d     = ga_d_q;
  assign int_ack  = int_ack_q;

endmodule

// File: rtl/amstrad_ram_sched.sv
// Shared-RAM scheduler: four CE_4 slots per microsecond, two video and two CPU.
// Owns the slot counter, RAM address mux and video word latch.
module amstrad_ram_sched
  import amstrad_pkg::*;
(
  input logic                 CLK,
  input logic                 RESET,
  amstrad_ram_sched_if.slave  bus
);

  logic [1:0]  phase_q, phase_d;
  logic [15:0] vram_q, vram_d;
  logic [14:0] ram_a_mux;
  logic        unused_bits;

  always_comb begin
    phase_d = phase_q;
    vram_d  = vram_q;
    if (bus.CE_4) begin
      phase_d = phase_q + 2'd1;
      if (phase_q == SLOT_VID1) vram_d = bus.ram_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= SLOT_VID0;
      vram_q  <= 16'h0000;
    end else begin
      phase_q <= phase_d;
      vram_q  <= vram_d;
    end
  end

  // Video slots address the CRTC screen word; CPU slots address the Z80 word.
  always_comb begin
    if (phase_q == SLOT_VID0 || phase_q == SLOT_VID1)
      ram_a_mux = {bus.crtc_ma[13:12], bus.crtc_ra[2:0], bus.crtc_ma[9:0]};
    else
      ram_a_mux = bus.cpu_a[15:1];
  end

  assign unused_bits = ^{bus.crtc_ma[11:10], bus.crtc_ra[4:3]};

  assign bus.phase  = phase_q;
  assign bus.vram_D = vram_q;
  assign bus.ram_a  = ram_a_mux;

  amstrad_cpu_sync u_cpu_sync (
    .clk      (CLK),
    .rst      (RESET),
    .ce_4     (bus.CE_4),
    .phase    (phase_q),
    .io_sel   (bus.cpu_a[15:14]),
    .a0       (bus.cpu_a[0]),
    .cpu_dout (bus.cpu_dout),
    .cpu_mreq (bus.cpu_mreq),
    .cpu_iorq (bus.cpu_iorq),
    .cpu_rd   (bus.cpu_rd),
    .cpu_wr   (bus.cpu_wr),
    .cpu_m1   (bus.cpu_m1),
    .ram_q    (bus.ram_q),
    .cpu_wait (bus.cpu_wait),
    .cpu_din  (bus.cpu_din),
    .ram_we   (bus.ram_we),
    .ram_be   (bus.ram_be),
    .ram_d    (bus.ram_d),
    .ga_we    (bus.ga_we),
    .ga_d     (bus.ga_d),
    .int_ack  (bus.INTack)
  );

endmodule

// File: tb/tb_amstrad_ram_sched.sv
// Bench for amstrad_ram_sched: vector table of CPU cycles through a scoreboard
// queue, plus slot-sequence, grant-edge, abort, CE-hold and reset sequences.
module tb_amstrad_ram_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  amstrad_ram_sched_if bus ();

  amstrad_ram_sched dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef enum logic [2:0] {K_MWR, K_MRD, K_IOWR, K_IORD, K_ACK} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] a;
    logic [7:0]  dout;
    logic [15:0] word;
    logic        we;
    logic [1:0]  be;
    logic        ga;
    logic        ack;
    logic        chk_din;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  bit          ce_en = 1'b1;
  logic [14:0] cpu_waddr = 15'h7FFF;
  logic [15:0] cpu_word  = 16'h0000;

  // CE_4 every fourth clock, updated 2 time units after the edge.
  always begin
    int cnt;
    cnt = 0;
    bus.CE_4 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ce_en) begin
        cnt = (cnt + 1) % 4;
        bus.CE_4 = (cnt == 0);
      end else begin
        bus.CE_4 = 1'b0;
      end
    end
  end

  function automatic logic [15:0] ram_fn(input logic [14:0] a, input logic [14:0] wa,
                                         input logic [15:0] w);
    if (a == wa) return w;
    return {a[7:0] ^ 8'hC3, a[14:7]};
  endfunction

  // Synchronous RAM model with one clock of read latency.
  always @(posedge clk) bus.ram_q <= ram_fn(bus.ram_a, cpu_waddr, cpu_word);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic strobes(input kind_e k, input bit on);
    bus.cpu_mreq = on && (k == K_MWR || k == K_MRD);
    bus.cpu_iorq = on && (k == K_IOWR || k == K_IORD || k == K_ACK);
    bus.cpu_rd   = on && (k == K_MRD || k == K_IORD);
    bus.cpu_wr   = on && (k == K_MWR || k == K_IOWR);
    bus.cpu_m1   = on && (k == K_ACK);
  endtask

  task automatic wait_phase(input logic [1:0] ph, input bit need_ce, input string name);
    int cyc;
    cyc = 0;
    while (!(bus.phase == ph && (!need_ce || bus.CE_4)) && cyc < 40) begin
      step();
      cyc++;
    end
    if (cyc >= 40) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int   we_n, ga_n, ack_n;
    logic [14:0] we_a;
    logic [1:0]  we_be;
    logic [7:0]  we_d, gd, din;
    bit   done;
    vec_t e;
    string tag;
    we_n = 0; ga_n = 0; ack_n = 0; we_a = '0; we_be = '0; we_d = '0; gd = '0; din = '0;
    done = 1'b0;
    tag = $sformatf("v%0d", idx);
    wait_phase(2'd0, 1'b0, tag);
    cpu_waddr    = v.a[15:1];
    cpu_word     = v.word;
    sb.push_back(v);
    bus.cpu_a    = v.a;
    bus.cpu_dout = v.dout;
    strobes(v.kind, 1'b1);
    #1;
    check({tag, "_wait_rise"}, 32'(bus.cpu_wait), 32'd1);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      step();
      if (bus.ram_we) begin we_n++; we_a = bus.ram_a; we_be = bus.ram_be; we_d = bus.ram_d; end
      if (bus.ga_we)  begin ga_n++; gd = bus.ga_d; end
      if (bus.INTack) ack_n++;
      if (!bus.cpu_wait) begin done = 1'b1; din = bus.cpu_din; end
    end
    strobes(v.kind, 1'b0);
    repeat (2) begin
      step();
      if (bus.ram_we) we_n++;
      if (bus.ga_we)  ga_n++;
      if (bus.INTack) ack_n++;
    end
    e = sb.pop_front();
    check({tag, "_wait_fall"}, 32'(done), 32'd1);
    check({tag, "_ram_we_cnt"}, 32'(we_n), 32'(e.we));
    check({tag, "_ga_we_cnt"}, 32'(ga_n), 32'(e.ga));
    check({tag, "_intack_cnt"}, 32'(ack_n), 32'(e.ack));
    if (e.we) begin
      check({tag, "_ram_a"}, 32'(we_a), 32'(e.a[15:1]));
      check({tag, "_ram_be"}, 32'(we_be), 32'(e.be));
      check({tag, "_ram_d"}, 32'(we_d), 32'(e.dout));
    end
    if (e.ga) check({tag, "_ga_d"}, 32'(gd), 32'(e.dout));
    if (e.chk_din) check({tag, "_cpu_din"}, 32'(din), 32'(e.din));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int ticks, we_ticks, wn;
    bit ce_at;
    logic [1:0] ph_hold;

    vecs[0] = '{K_MWR,  16'hC001, 8'hA5, 16'h0000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{K_MRD,  16'h4000, 8'h00, 16'h1234, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h34};
    vecs[2] = '{K_MRD,  16'h4001, 8'h00, 16'h1234, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h12};
    vecs[3] = '{K_IOWR, 16'h7F00, 8'h8C, 16'h0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{K_ACK,  16'h0000, 8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hFF};
    vecs[5] = '{K_MWR,  16'h0000, 8'h3C, 16'h0000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{K_MRD,  16'h2001, 8'h00, 16'hABCD, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'hAB};
    vecs[7] = '{K_IORD, 16'hBC00, 8'h00, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[8] = '{K_IOWR, 16'h8000, 8'h66, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1'b1;
    bus.crtc_ma  = 14'h3001;
    bus.crtc_ra  = 5'd2;
    bus.cpu_a    = 16'h0000;
    bus.cpu_dout = 8'h00;
    strobes(K_MRD, 1'b0);
    repeat (3) step();

    check("rst_phase",   32'(bus.phase),    32'd0);
    check("rst_wait",    32'(bus.cpu_wait), 32'd0);
    check("rst_ram_we",  32'(bus.ram_we),   32'd0);
    check("rst_ram_be",  32'(bus.ram_be),   32'd0);
    check("rst_ga_we",   32'(bus.ga_we),    32'd0);
    check("rst_intack",  32'(bus.INTack),   32'd0);
    check("rst_cpu_din", 32'(bus.cpu_din),  32'hFF);
    check("rst_vram",    32'(bus.vram_D),   32'd0);
    check("rst_ga_d",    32'(bus.ga_d),     32'd0);
    check("rst_ram_d",   32'(bus.ram_d),    32'd0);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int cyc;
      cyc = 0;
      do begin
        ce_at = bus.CE_4;
        step();
        cyc++;
      end while (!ce_at && cyc < 10);
      check($sformatf("phase_seq%0d", i), 32'(bus.phase), 32'((i + 1) % 4));
    end

    wait_phase(2'd0, 1'b0, "vid_ph0");
    check("vid_ram_a_ph0", 32'(bus.ram_a), 32'h6801);
    wait_phase(2'd1, 1'b1, "vid_ph1");
    check("vid_ram_a_ph1", 32'(bus.ram_a), 32'h6801);
    step();
    check("vid_vram_D", 32'(bus.vram_D), 32'hC2D0);

    foreach (vecs[i]) run_txn(vecs[i], i);

    // Request raised on the slot-2 tick itself misses that grant.
    wait_phase(2'd2, 1'b1, "edge");
    cpu_waddr = 15'h4001;
    cpu_word  = 16'h0000;
    bus.cpu_a = 16'h8002;
    bus.cpu_dout = 8'h5A;
    strobes(K_MWR, 1'b1);
    ticks = 0; we_ticks = 0; wn = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      ce_at = bus.CE_4;
      step();
      if (ce_at) ticks++;
      if (bus.ram_we) begin wn++; we_ticks = ticks; end
      if (!bus.cpu_wait) break;
    end
    strobes(K_MWR, 1'b0);
    step();
    check("edge_ram_we_cnt", 32'(wn), 32'd1);
    check("edge_grant_tick", 32'(we_ticks), 32'd5);
    check("edge_wait_ticks", 32'(ticks), 32'd6);

    // Request dropped while waiting in SYNC.
    wait_phase(2'd0, 1'b0, "abort");
    bus.cpu_a = 16'h0010;
    strobes(K_MWR, 1'b1);
    step();
    strobes(K_MWR, 1'b0);
    #1;
    check("abort_wait_low", 32'(bus.cpu_wait), 32'd0);
    wn = 0;
    repeat (8) begin
      step();
      if (bus.ram_we) wn++;
    end
    check("abort_ram_we_cnt", 32'(wn), 32'd0);

    // No CE_4: phase must hold.
    ce_en = 1'b0;
    repeat (2) step();
    ph_hold = bus.phase;
    repeat (6) step();
    check("ce_low_hold", 32'(bus.phase), 32'(ph_hold));
    ce_en = 1'b1;
    repeat (4) step();

    // Reset sampled on the grant edge drops the pending write.
    wait_phase(2'd0, 1'b0, "rst_mid0");
    bus.cpu_a = 16'h0020;
    bus.cpu_dout = 8'h77;
    strobes(K_MWR, 1'b1);
    wait_phase(2'd2, 1'b1, "rst_mid2");
    rst = 1'b1;
    step();
    check("rstmid_ram_we", 32'(bus.ram_we), 32'd0);
    check("rstmid_wait",   32'(bus.cpu_wait), 32'd0);
    check("rstmid_phase",  32'(bus.phase), 32'd0);
    strobes(K_MWR, 1'b0);
    step();
    rst = 1'b0;
    wn = 0;
    repeat (8) begin
      step();
      if (bus.ram_we) wn++;
    end
    check("rstmid_no_write", 32'(wn), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
